// File: rtl/music_pkg.sv
// Shared definitions for the voice mixer: pan codes and the mixer FSM states.
package music_pkg;

  localparam logic [1:0] PAN_CENTER = 2'b00;
  localparam logic [1:0] PAN_LEFT   = 2'b01;
  localparam logic [1:0] PAN_RIGHT  = 2'b10;
  localparam logic [1:0] PAN_HALF   = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StAccum = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/voice_pan_gain.sv
// Per-voice left/right contribution from pan code, mute and mono/stereo mode.
module voice_pan_gain
  import music_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [1:0]          pan,
  input  logic                       mute,
  input  logic                       stereo_on,
  output logic signed [SAMPLE_W-1:0] left,
  output logic signed [SAMPLE_W-1:0] right
);

  always_comb begin
    left  = sample;
    right = sample;
    if (mute) begin
      left  = '0;
      right = '0;
    end else if (stereo_on) begin
      case (pan)
        PAN_LEFT:  right = sample >>> 2;
        PAN_RIGHT: left  = sample >>> 2;
        PAN_HALF: begin
          left  = sample >>> 1;
          right = sample >>> 1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stereo_voice_mixer.sv
// Sequential stereo mixer: snapshots all voices on start, accumulates one voice per
// cycle, then attenuates and saturates into registered left/right outputs.
module stereo_voice_mixer
  import music_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned ATTEN      = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stereo_on,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  input  logic [NUM_VOICES*2-1:0]        voice_pan,
  input  logic [NUM_VOICES-1:0]          voice_mute,
  output logic [SAMPLE_W-1:0]            sample_left,
  output logic [SAMPLE_W-1:0]            sample_right,
  output logic                           sample_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  state_e r_state, w_state_next;

  logic [NUM_VOICES*SAMPLE_W-1:0] r_samples;
  logic [NUM_VOICES*2-1:0]        r_pan;
  logic [NUM_VOICES-1:0]          r_mute;
  logic                           r_stereo;
  logic [IDX_W-1:0]               r_idx;
  logic signed [ACC_W-1:0]        r_acc_l, r_acc_r;
  logic [SAMPLE_W-1:0]            r_out_l, r_out_r;
  logic                           r_overrun;

  logic signed [SAMPLE_W-1:0] w_cur_sample, w_gain_l, w_gain_r;
  logic [1:0]                 w_cur_pan;
  logic                       w_cur_mute, w_accept, w_last;
  logic signed [ACC_W-1:0]    w_sum_l, w_sum_r, w_shift_l, w_shift_r;
  logic [SAMPLE_W-1:0]        w_sat_l, w_sat_r;

  assign w_accept = start && (r_state != StAccum);
  assign w_last   = (r_idx == IDX_W'(NUM_VOICES - 1));

  always_comb begin
    w_cur_sample = '0;
    w_cur_pan    = '0;
    w_cur_mute   = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_sample = r_samples[i*SAMPLE_W +: SAMPLE_W];
        w_cur_pan    = r_pan[2*i +: 2];
        w_cur_mute   = r_mute[i];
      end
    end
  end

  voice_pan_gain #(
    .SAMPLE_W(SAMPLE_W)
  ) u_gain (
    .sample   (w_cur_sample),
    .pan      (w_cur_pan),
    .mute     (w_cur_mute),
    .stereo_on(r_stereo),
    .left     (w_gain_l),
    .right    (w_gain_r)
  );

  assign w_sum_l   = r_acc_l + {{(ACC_W-SAMPLE_W){w_gain_l[SAMPLE_W-1]}}, w_gain_l};
  assign w_sum_r   = r_acc_r + {{(ACC_W-SAMPLE_W){w_gain_r[SAMPLE_W-1]}}, w_gain_r};
  assign w_shift_l = w_sum_l >>> ATTEN;
  assign w_shift_r = w_sum_r >>> ATTEN;

  always_comb begin
    w_sat_l = w_shift_l[SAMPLE_W-1:0];
    w_sat_r = w_shift_r[SAMPLE_W-1:0];
    if (w_shift_l > SAT_MAX) w_sat_l = SAT_MAX[SAMPLE_W-1:0];
    if (w_shift_l < SAT_MIN) w_sat_l = SAT_MIN[SAMPLE_W-1:0];
    if (w_shift_r > SAT_MAX) w_sat_r = SAT_MAX[SAMPLE_W-1:0];
    if (w_shift_r < SAT_MIN) w_sat_r = SAT_MIN[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (start) w_state_next = StAccum;
      StAccum: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = start ? StAccum : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy         = (r_state == StAccum);
    sample_valid = (r_state == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_samples <= '0;
      r_pan     <= '0;
      r_mute    <= '0;
      r_stereo  <= 1'b0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_out_l   <= '0;
      r_out_r   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (start && r_state == StAccum) r_overrun <= 1'b1;
      if (w_accept) begin
        r_samples <= voice_samples;
        r_pan     <= voice_pan;
        r_mute    <= voice_mute;
        r_stereo  <= stereo_on;
        r_idx     <= '0;
        r_acc_l   <= '0;
        r_acc_r   <= '0;
      end else if (r_state == StAccum) begin
        r_acc_l <= w_sum_l;
        r_acc_r <= w_sum_r;
        r_idx   <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_out_l <= w_sat_l;
          r_out_r <= w_sat_r;
        end
      end
    end
  end

  assign sample_left  = r_out_l;
  assign sample_right = r_out_r;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_stereo_voice_mixer.sv
// Randomised and directed bench for stereo_voice_mixer; two instances (ATTEN 0 and 1)
// share stimulus and are compared against an arithmetic reference mix.
module tb_stereo_voice_mixer;

  localparam int N = 3;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stereo_on = 1'b0;
  logic [N*W-1:0]   voice_samples = '0;
  logic [N*2-1:0]   voice_pan = '0;
  logic [N-1:0]     voice_mute = '0;
  logic signed [W-1:0] l0, r0, l1, r1;
  logic             valid0, valid1, busy0, busy1, ovr0, ovr1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stereo_voice_mixer #(.NUM_VOICES(N), .SAMPLE_W(W), .ATTEN(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .stereo_on(stereo_on),
    .voice_samples(voice_samples), .voice_pan(voice_pan), .voice_mute(voice_mute),
    .sample_left(l0), .sample_right(r0), .sample_valid(valid0), .busy(busy0),
    .overrun(ovr0)
  );

  stereo_voice_mixer #(.NUM_VOICES(N), .SAMPLE_W(W), .ATTEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .stereo_on(stereo_on),
    .voice_samples(voice_samples), .voice_pan(voice_pan), .voice_mute(voice_mute),
    .sample_left(l1), .sample_right(r1), .sample_valid(valid1), .busy(busy1),
    .overrun(ovr1)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference mix: pan gains are quarter/half of the sample rounded toward -inf.
  task automatic model(input logic [N*W-1:0] smp, input logic [N*2-1:0] pan,
                       input logic [N-1:0] mute, input logic st, input int atten,
                       output int l, output int r);
    int sl, sr, s, lim_hi, lim_lo;
    sl = 0;
    sr = 0;
    lim_hi = (1 << (W - 1)) - 1;
    lim_lo = -(1 << (W - 1));
    for (int i = 0; i < N; i++) begin
      s = int'($signed(smp[i*W +: W]));
      if (mute[i]) continue;
      if (!st || pan[2*i +: 2] == 2'd0) begin
        sl += s;
        sr += s;
      end else if (pan[2*i +: 2] == 2'd1) begin
        sl += s;
        sr += $rtoi($floor(real'(s) / 4.0));
      end else if (pan[2*i +: 2] == 2'd2) begin
        sl += $rtoi($floor(real'(s) / 4.0));
        sr += s;
      end else begin
        sl += $rtoi($floor(real'(s) / 2.0));
        sr += $rtoi($floor(real'(s) / 2.0));
      end
    end
    sl = $rtoi($floor(real'(sl) / real'(1 << atten)));
    sr = $rtoi($floor(real'(sr) / real'(1 << atten)));
    l = (sl > lim_hi) ? lim_hi : (sl < lim_lo) ? lim_lo : sl;
    r = (sr > lim_hi) ? lim_hi : (sr < lim_lo) ? lim_lo : sr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid0 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic check_outputs(input string tag, input logic [N*W-1:0] smp,
                               input logic [N*2-1:0] pan, input logic [N-1:0] mute,
                               input logic st);
    int el, er;
    model(smp, pan, mute, st, 0, el, er);
    check_val({tag, "_l_a0"}, int'(l0), el);
    check_val({tag, "_r_a0"}, int'(r0), er);
    model(smp, pan, mute, st, 1, el, er);
    check_val({tag, "_l_a1"}, int'(l1), el);
    check_val({tag, "_r_a1"}, int'(r1), er);
  endtask

  // One full request from idle: latency, busy, result and single-cycle valid.
  task automatic run_mix(input string tag, input bit scramble);
    logic [N*W-1:0] smp;
    logic [N*2-1:0] pan;
    logic [N-1:0]   mute;
    logic           st;
    int             n;
    smp  = voice_samples;
    pan  = voice_pan;
    mute = voice_mute;
    st   = stereo_on;
    start = 1'b1;
    step();
    start = 1'b0;
    check_val({tag, "_busy"}, int'(busy0 & busy1), 1);
    if (scramble) begin
      voice_samples = {$urandom, $urandom};
      voice_mute    = 3'($urandom);
      stereo_on     = ~stereo_on;
    end
    wait_valid(n);
    check_val({tag, "_latency"}, n + 1, N + 1);
    check_outputs(tag, smp, pan, mute, st);
    step();
    check_val({tag, "_valid_drop"}, int'(valid0 | valid1), 0);
  endtask

  initial begin
    logic [N*W-1:0] smp;
    logic [N*2-1:0] pan;
    logic [N-1:0]   mute;
    logic           st;
    int             n, pulses;

    step();
    step();
    reset = 1'b0;
    check_val("rst_outputs", int'(l0) | int'(r0) | int'(l1) | int'(r1), 0);
    check_val("rst_flags", int'({valid0, busy0, ovr0, valid1, busy1, ovr1}), 0);

    // Mono, 100/200/300
    voice_samples = {16'sd300, 16'sd200, 16'sd100};
    voice_pan     = 6'b11_10_01;
    voice_mute    = 3'b000;
    stereo_on     = 1'b0;
    run_mix("mono", 1'b0);

    // Stereo pans left/right/center
    voice_samples = {16'sd1000, 16'sd800, 16'sd400};
    voice_pan     = {2'b00, 2'b10, 2'b01};
    stereo_on     = 1'b1;
    run_mix("stereo", 1'b0);

    // Saturation both polarities
    stereo_on     = 1'b0;
    voice_samples = {3{16'sh7fff}};
    run_mix("sat_pos", 1'b0);
    voice_samples = {3{16'sh8000}};
    run_mix("sat_neg", 1'b0);

    // Snapshot and mute of voice 1
    voice_samples = {16'sd3000, 16'sd2000, 16'sd1000};
    voice_pan     = 6'b00_00_00;
    voice_mute    = 3'b010;
    stereo_on     = 1'b1;
    run_mix("snapshot", 1'b1);

    // Start while accumulating is dropped and flagged
    voice_samples = {16'sd123, -16'sd456, 16'sd789};
    voice_pan     = 6'b11_01_10;
    voice_mute    = 3'b000;
    stereo_on     = 1'b1;
    smp = voice_samples; pan = voice_pan; mute = voice_mute; st = stereo_on;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    voice_samples = {16'sd5, 16'sd5, 16'sd5};
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("ovr_set", int'(ovr0 & ovr1), 1);
    wait_valid(n);
    check_val("ovr_latency", n + 3, N + 1);
    check_outputs("ovr", smp, pan, mute, st);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid0) pulses++;
    end
    check_val("ovr_single_pulse", pulses, 0);
    check_val("ovr_sticky", int'(ovr0 & ovr1), 1);

    // Back-to-back: second start lands in the DONE cycle
    voice_samples = {16'sd10, 16'sd20, 16'sd30};
    stereo_on     = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(n);
    check_val("b2b_first_latency", n + 1, N + 1);
    voice_samples = {-16'sd1000, 16'sd2500, 16'sd7000};
    voice_pan     = 6'b01_11_10;
    stereo_on     = 1'b1;
    smp = voice_samples; pan = voice_pan; mute = voice_mute; st = stereo_on;
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("b2b_busy", int'(busy0), 1);
    wait_valid(n);
    check_val("b2b_second_latency", n + 1, N + 1);
    check_outputs("b2b", smp, pan, mute, st);
    step();

    // Reset in the middle of accumulation
    voice_samples = {16'sd9, 16'sd9, 16'sd9};
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("midrst_outputs", int'(l0) | int'(r0) | int'(l1) | int'(r1), 0);
    check_val("midrst_flags", int'({valid0, busy0, ovr0, valid1, busy1, ovr1}), 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid0 || valid1) pulses++;
    end
    check_val("midrst_no_valid", pulses, 0);

    // Random mixes
    for (int k = 0; k < 24; k++) begin
      voice_samples = {$urandom, $urandom};
      if (k % 4 == 0) voice_samples = {3{16'($urandom_range(0, 1) ? 16'h7ff0 : 16'h8010)}};
      voice_pan  = 6'($urandom);
      voice_mute = 3'($urandom);
      stereo_on  = 1'($urandom);
      run_mix($sformatf("rand%0d", k), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
